dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port data memory
//  (sync write, combinational read, word-indexed).

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port data memory: one access every
// two cycles, registered per-port responses two cycles after acceptance.
module dmem_arbiter #(
   parameter int DEPTH = 1024,
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_rdata,
   output logic        rsp0_err,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_rdata,
   output logic        rsp1_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic        busy
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t      state_r, state_s;
   logic        last_grant_r;
   logic        lat_we_r;
   logic        lat_port_r;
   logic [31:0] lat_addr_r;
   logic [31:0] lat_wdata_r;
   logic        grant_s;
   logic        hs_s;
   logic        in_range_s;
   logic [31:0] rsp_data_s;

   // Ties alternate away from the previous winner in round-robin mode.
   function automatic logic pick_port(input logic v0, input logic v1,
                                      input logic last, input logic rr);
      logic p;
      if (v0 && v1) begin
         if (rr) begin
            p = ~last;
         end else begin
            p = 1'b0;
         end
      end else begin
         p = v1;
      end
      return p;
   endfunction

   // Arbitration, handshake and next-state selection.
   always_comb begin
      state_s    = state_r;
      grant_s    = 1'b0;
      hs_s       = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_r)
         IDLE: begin
            grant_s = pick_port(req0_valid, req1_valid, last_grant_r, RR_EN);
            if (rst && (req0_valid || req1_valid)) begin
               hs_s       = 1'b1;
               state_s    = ACCESS;
               req0_ready = ~grant_s;
               req1_ready = grant_s;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Memory-side drive and response data for the access in flight.
   always_comb begin
      in_range_s = (lat_addr_r < DEPTH_W);
      if (!lat_we_r && in_range_s) begin
         rsp_data_s = mem_rd;
      end else begin
         rsp_data_s = 32'd0;
      end
      if ((state_r == ACCESS) && lat_we_r && in_range_s && rst) begin
         mem_we = 1'b1;
      end else begin
         mem_we = 1'b0;
      end
   end

   assign mem_a  = lat_addr_r;
   assign mem_wd = lat_wdata_r;
   assign busy   = (state_r == ACCESS);

   // State, request latch and per-port response registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         lat_we_r     <= 1'b0;
         lat_port_r   <= 1'b0;
         lat_addr_r   <= 32'd0;
         lat_wdata_r  <= 32'd0;
         rsp0_valid   <= 1'b0;
         rsp0_rdata   <= 32'd0;
         rsp0_err     <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp1_rdata   <= 32'd0;
         rsp1_err     <= 1'b0;
      end else begin
         state_r    <= state_s;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         if (hs_s) begin
            last_grant_r <= grant_s;
            lat_port_r   <= grant_s;
            lat_we_r     <= grant_s ? req1_we    : req0_we;
            lat_addr_r   <= grant_s ? req1_addr  : req0_addr;
            lat_wdata_r  <= grant_s ? req1_wdata : req0_wdata;
         end
         // Response lands on the edge that closes the ACCESS cycle.
         if (state_r == ACCESS) begin
            if (lat_port_r == 1'b0) begin
               rsp0_valid <= 1'b1;
               rsp0_rdata <= rsp_data_s;
               rsp0_err   <= ~in_range_s;
            end else begin
               rsp1_valid <= 1'b1;
               rsp1_rdata <= rsp_data_s;
               rsp1_err   <= ~in_range_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each with
// its own memory, checked against a cycle-level transaction model of the arbiter.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] a0 = 32'd0, a1 = 32'd0, d0 = 32'd0, d1 = 32'd0;
   logic        rdy0[2], rdy1[2], rv0[2], rv1[2], re0[2], re1[2], mwe[2], bsy[2];
   logic [31:0] rd0[2], rd1[2], ma[2], mwd[2], mrd[2];
   logic [31:0] mem0[1024];
   logic [31:0] mem1[1024];
   logic        clr_en = 1'b0, poke_en = 1'b0;
   logic [9:0]  poke_a = 10'd0;
   logic [31:0] poke_d = 32'd0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit cur      = 1'b0;

   // transaction-level model state
   logic [31:0] ref_mem[1024];
   logic        acc_prev, p_port, p_we, last_grant, rsp_pend, rsp_port;
   logic [31:0] p_addr, p_wdata;
   logic [31:0] last_rd[2];
   logic        last_err[2];

   // observations of the checked instance from the latest step
   logic        ob_rdy0, ob_rdy1, ob_we, ob_rv0, ob_rv1, ob_re0, ob_busy;
   logic [31:0] ob_rd0, ob_ma;

   dmem_arbiter #(.DEPTH(1024), .RR_EN(1'b1)) u_rr (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(rdy0[0]), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
      .rsp0_valid(rv0[0]), .rsp0_rdata(rd0[0]), .rsp0_err(re0[0]),
      .req1_valid(v1), .req1_ready(rdy1[0]), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
      .rsp1_valid(rv1[0]), .rsp1_rdata(rd1[0]), .rsp1_err(re1[0]),
      .mem_we(mwe[0]), .mem_a(ma[0]), .mem_wd(mwd[0]), .mem_rd(mrd[0]), .busy(bsy[0]));

   dmem_arbiter #(.DEPTH(1024), .RR_EN(1'b0)) u_fx (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(rdy0[1]), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
      .rsp0_valid(rv0[1]), .rsp0_rdata(rd0[1]), .rsp0_err(re0[1]),
      .req1_valid(v1), .req1_ready(rdy1[1]), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
      .rsp1_valid(rv1[1]), .rsp1_rdata(rd1[1]), .rsp1_err(re1[1]),
      .mem_we(mwe[1]), .mem_a(ma[1]), .mem_wd(mwd[1]), .mem_rd(mrd[1]), .busy(bsy[1]));

   function automatic logic [31:0] init_val(input int i);
      return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003);
   endfunction

   // out-of-range reads return junk so the arbiter's zeroing is visible
   always_comb begin
      mrd[0] = (ma[0] < 32'd1024) ? mem0[ma[0][9:0]] : 32'hBAD0_BAD0;
      mrd[1] = (ma[1] < 32'd1024) ? mem1[ma[1][9:0]] : 32'hBAD0_BAD0;
   end

   always @(posedge clk) begin
      if (clr_en) begin
         for (int i = 0; i < 1024; i++) begin
            mem0[i] <= init_val(i);
            mem1[i] <= init_val(i);
         end
      end else if (poke_en) begin
         mem0[poke_a] <= poke_d;
         mem1[poke_a] <= poke_d;
      end else begin
         if (mwe[0] && ma[0] < 32'd1024) mem0[ma[0][9:0]] <= mwd[0];
         if (mwe[1] && ma[1] < 32'd1024) mem1[ma[1][9:0]] <= mwd[1];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One clock cycle: check the checked instance against the model mid-cycle, then advance.
   task automatic step();
      logic g, hs, ewe, erv0, erv1, inr;
      @(negedge clk);
      g = 1'b0;
      hs = 1'b0;
      if (rst && !acc_prev && (v0 || v1)) begin
         hs = 1'b1;
         if (v0 && v1) g = (cur == 1'b0) ? ~last_grant : 1'b0;
         else g = v1;
      end
      ewe  = acc_prev && p_we && (p_addr < 32'd1024) && rst;
      erv0 = rsp_pend && !rsp_port;
      erv1 = rsp_pend && rsp_port;
      n_checks += 10;
      if (rdy0[cur] !== (hs & ~g)) begin n_fail++; $display("FAIL ready0 cyc %0d: got %b expected %b", cyc, rdy0[cur], hs & ~g); end
      if (rdy1[cur] !== (hs & g)) begin n_fail++; $display("FAIL ready1 cyc %0d: got %b expected %b", cyc, rdy1[cur], hs & g); end
      if (mwe[cur] !== ewe) begin n_fail++; $display("FAIL mem_we cyc %0d: got %b expected %b", cyc, mwe[cur], ewe); end
      if (bsy[cur] !== acc_prev) begin n_fail++; $display("FAIL busy cyc %0d: got %b expected %b", cyc, bsy[cur], acc_prev); end
      if (rv0[cur] !== erv0) begin n_fail++; $display("FAIL rsp0_valid cyc %0d: got %b expected %b", cyc, rv0[cur], erv0); end
      if (rv1[cur] !== erv1) begin n_fail++; $display("FAIL rsp1_valid cyc %0d: got %b expected %b", cyc, rv1[cur], erv1); end
      if (rd0[cur] !== last_rd[0]) begin n_fail++; $display("FAIL rsp0_rdata cyc %0d: got %h expected %h", cyc, rd0[cur], last_rd[0]); end
      if (re0[cur] !== last_err[0]) begin n_fail++; $display("FAIL rsp0_err cyc %0d: got %b expected %b", cyc, re0[cur], last_err[0]); end
      if (rd1[cur] !== last_rd[1]) begin n_fail++; $display("FAIL rsp1_rdata cyc %0d: got %h expected %h", cyc, rd1[cur], last_rd[1]); end
      if (re1[cur] !== last_err[1]) begin n_fail++; $display("FAIL rsp1_err cyc %0d: got %b expected %b", cyc, re1[cur], last_err[1]); end
      if (acc_prev) begin
         n_checks++;
         if (ma[cur] !== p_addr) begin n_fail++; $display("FAIL mem_a cyc %0d: got %h expected %h", cyc, ma[cur], p_addr); end
      end
      if (ewe) begin
         n_checks++;
         if (mwd[cur] !== p_wdata) begin n_fail++; $display("FAIL mem_wd cyc %0d: got %h expected %h", cyc, mwd[cur], p_wdata); end
      end
      ob_rdy0 = rdy0[cur]; ob_rdy1 = rdy1[cur]; ob_we = mwe[cur]; ob_busy = bsy[cur];
      ob_rv0 = rv0[cur]; ob_rv1 = rv1[cur]; ob_re0 = re0[cur]; ob_rd0 = rd0[cur]; ob_ma = ma[cur];
      rsp_pend = 1'b0;
      if (!rst) begin
         acc_prev = 1'b0; last_grant = 1'b1;
         last_rd[0] = 32'd0; last_rd[1] = 32'd0; last_err[0] = 1'b0; last_err[1] = 1'b0;
      end else begin
         if (acc_prev) begin
            inr = (p_addr < 32'd1024);
            rsp_pend = 1'b1;
            rsp_port = p_port;
            last_err[p_port] = !inr;
            last_rd[p_port] = (!p_we && inr) ? ref_mem[p_addr[9:0]] : 32'd0;
            if (p_we && inr) ref_mem[p_addr[9:0]] = p_wdata;
         end
         acc_prev = hs;
         if (hs) begin
            last_grant = g; p_port = g;
            p_we = g ? we1 : we0; p_addr = g ? a1 : a0; p_wdata = g ? d1 : d0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hs && !g) v0 = 1'b0;
      if (hs && g) v1 = 1'b0;
   endtask

   task automatic do_reset(input bit k);
      rst = 1'b0; v0 = 1'b0; v1 = 1'b0; clr_en = 1'b1; cur = k;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr_en = 1'b0; rst = 1'b1;
      acc_prev = 1'b0; rsp_pend = 1'b0; rsp_port = 1'b0; last_grant = 1'b1;
      p_port = 1'b0; p_we = 1'b0; p_addr = 32'd0; p_wdata = 32'd0;
      last_rd[0] = 32'd0; last_rd[1] = 32'd0; last_err[0] = 1'b0; last_err[1] = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
   endtask

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      poke_en = 1'b1; poke_a = a; poke_d = d;
      step();
      poke_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic drain();
      for (int i = 0; i < 8; i++) step();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0: r = 32'd1023;
         1: r = 32'd1024;
         2: r = $urandom;
         default: r = 32'($urandom_range(0, 31));
      endcase
      return r;
   endfunction

   task automatic test_reset();
      do_reset(1'b0);
      rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks += 10;
      if (rdy0[0] !== 1'b0 || rdy1[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b expected 00", rdy0[0], rdy1[0]); end
      if (rv0[0] !== 1'b0 || rv1[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rv0[0], rv1[0]); end
      if (re0[0] !== 1'b0 || re1[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", re0[0], re1[0]); end
      if (rd0[0] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 0", rd0[0]); end
      if (rd1[0] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata1: got %h expected 0", rd1[0]); end
      if (mwe[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mwe[0]); end
      if (ma[0] !== 32'd0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected 0", ma[0]); end
      if (mwd[0] !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wd: got %h expected 0", mwd[0]); end
      if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bsy[0]); end
      if (rdy0[1] !== 1'b0 || rdy1[1] !== 1'b0) begin n_fail++; $display("FAIL reset_ready_fixed: got %b%b expected 00", rdy0[1], rdy1[1]); end
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
   endtask

   task automatic test_read_basic();
      poke(10'd28, 32'h0000_0020);
      v0 = 1'b1; we0 = 1'b0; a0 = 32'd28;
      step();
      n_checks++; if (ob_rdy0 !== 1'b1) begin n_fail++; $display("FAIL t1_accept: got %b expected 1", ob_rdy0); end
      step();
      n_checks++; if (ob_we !== 1'b0) begin n_fail++; $display("FAIL t1_mem_we: got %b expected 0", ob_we); end
      step();
      n_checks += 2;
      if (ob_rv0 !== 1'b1 || ob_rv1 !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_valid: got %b%b expected 10", ob_rv0, ob_rv1); end
      if (ob_rd0 !== 32'h0000_0020) begin n_fail++; $display("FAIL t1_rdata: got %h expected 00000020", ob_rd0); end
   endtask

   task automatic test_write_read();
      v1 = 1'b1; we1 = 1'b1; a1 = 32'd5; d1 = 32'hDEAD_BEEF;
      step();
      n_checks++; if (ob_rdy1 !== 1'b1) begin n_fail++; $display("FAIL t2_accept1: got %b expected 1", ob_rdy1); end
      step();
      n_checks += 2;
      if (ob_we !== 1'b1) begin n_fail++; $display("FAIL t2_mem_we: got %b expected 1", ob_we); end
      if (ob_ma !== 32'd5) begin n_fail++; $display("FAIL t2_mem_a: got %h expected 5", ob_ma); end
      v0 = 1'b1; we0 = 1'b0; a0 = 32'd5;
      step();
      n_checks += 2;
      if (ob_rv1 !== 1'b1) begin n_fail++; $display("FAIL t2_rsp1: got %b expected 1", ob_rv1); end
      if (ob_rdy0 !== 1'b1) begin n_fail++; $display("FAIL t2_same_cycle_accept: got %b expected 1", ob_rdy0); end
      step();
      step();
      n_checks += 2;
      if (ob_rv0 !== 1'b1 || ob_rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t2_readback: got %b/%h expected 1/deadbeef", ob_rv0, ob_rd0); end
      if (ob_re0 !== 1'b0) begin n_fail++; $display("FAIL t2_err: got %b expected 0", ob_re0); end
   endtask

   task automatic test_out_of_range();
      v0 = 1'b1; we0 = 1'b1; a0 = 32'd1024; d0 = 32'h0000_1234;
      step();
      step();
      n_checks++; if (ob_we !== 1'b0) begin n_fail++; $display("FAIL t4_mem_we: got %b expected 0", ob_we); end
      v0 = 1'b1; we0 = 1'b0; a0 = 32'd1023;
      step();
      n_checks += 2;
      if (ob_rv0 !== 1'b1 || ob_re0 !== 1'b1) begin n_fail++; $display("FAIL t4_err: got %b/%b expected 1/1", ob_rv0, ob_re0); end
      if (ob_rd0 !== 32'd0) begin n_fail++; $display("FAIL t4_rdata: got %h expected 0", ob_rd0); end
      step();
      step();
      n_checks += 2;
      if (ob_rd0 !== init_val(1023) || ob_re0 !== 1'b0) begin n_fail++; $display("FAIL t4_mem1023: got %h/%b expected %h/0", ob_rd0, ob_re0, init_val(1023)); end
      if (mem0[1023] !== init_val(1023)) begin n_fail++; $display("FAIL t4_mem_array: got %h expected %h", mem0[1023], init_val(1023)); end
   endtask

   task automatic test_reset_mid_access();
      v0 = 1'b1; we0 = 1'b1; a0 = 32'd7; d0 = 32'h0000_CAFE;
      step();
      rst = 1'b0;
      step();
      n_checks++; if (ob_we !== 1'b0) begin n_fail++; $display("FAIL t5_mem_we: got %b expected 0", ob_we); end
      rst = 1'b1;
      v0 = 1'b1; we0 = 1'b0; a0 = 32'd7;
      v1 = 1'b1; we1 = 1'b0; a1 = 32'd9;
      step();
      n_checks += 4;
      if (ob_busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy: got %b expected 0", ob_busy); end
      if (ob_rv0 !== 1'b0 || ob_rv1 !== 1'b0) begin n_fail++; $display("FAIL t5_no_rsp: got %b%b expected 00", ob_rv0, ob_rv1); end
      if (ob_rdy0 !== 1'b1) begin n_fail++; $display("FAIL t5_grant0: got %b expected 1", ob_rdy0); end
      if (mem0[7] !== init_val(7)) begin n_fail++; $display("FAIL t5_mem7: got %h expected %h", mem0[7], init_val(7)); end
      drain();
   endtask

   task automatic test_arbitration(input bit k);
      int grants[$];
      int r1_cnt;
      do_reset(k);
      r1_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (!v0) begin v0 = 1'b1; we0 = 1'b0; a0 = 32'($urandom_range(0, 1023)); end
         if (!v1) begin v1 = 1'b1; we1 = 1'b0; a1 = 32'($urandom_range(0, 1023)); end
         step();
         if (ob_rdy0) grants.push_back(0);
         if (ob_rdy1) begin grants.push_back(1); r1_cnt++; end
      end
      drain();
      n_checks++;
      if (grants.size() != 4) begin n_fail++; $display("FAIL t3_grant_count rr=%0d: got %0d expected 4", k == 1'b0, grants.size()); end
      for (int i = 0; i < grants.size() && i < 4; i++) begin
         n_checks++;
         if (grants[i] != ((k == 1'b0) ? (i % 2) : 0)) begin
            n_fail++; $display("FAIL t3_grant_order[%0d] rr=%0d: got %0d expected %0d", i, k == 1'b0, grants[i], (k == 1'b0) ? (i % 2) : 0);
         end
      end
      if (k) begin
         n_checks++;
         if (r1_cnt != 0) begin n_fail++; $display("FAIL t3_fixed_ready1: got %0d grants expected 0", r1_cnt); end
      end
   endtask

   task automatic test_fixed_hold();
      do_reset(1'b1);
      v1 = 1'b1; we1 = 1'b1; a1 = 32'd12; d1 = $urandom;
      for (int i = 0; i < 5; i++) begin
         if (i == 0 || i == 2) begin v0 = 1'b1; we0 = 1'b0; a0 = 32'(i); end
         step();
         n_checks++;
         if (ob_rdy1 !== ((i == 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL t6_ready1 cycle %0d: got %b expected %b", i, ob_rdy1, (i == 4) ? 1'b1 : 1'b0); end
      end
      drain();
   endtask

   task automatic test_random(input bit k, input int n);
      do_reset(k);
      for (int i = 0; i < n; i++) begin
         if (!v0 && $urandom_range(0, 3) != 0) begin v0 = 1'b1; we0 = 1'($urandom_range(0, 1)); a0 = rand_addr(); d0 = $urandom; end
         if (!v1 && $urandom_range(0, 3) != 0) begin v1 = 1'b1; we1 = 1'($urandom_range(0, 1)); a1 = rand_addr(); d1 = $urandom; end
         rst = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
         step();
      end
      rst = 1'b1;
      drain();
   endtask

   initial begin
      test_reset();
      do_reset(1'b0);
      test_read_basic();
      test_write_read();
      test_out_of_range();
      test_reset_mid_access();
      test_arbitration(1'b0);
      test_arbitration(1'b1);
      test_fixed_hold();
      test_random(1'b0, 400);
      test_random(1'b1, 400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
